dff_pipe_bank: RTL and testbench
================================

// Module: dff_pipe_bank
// PURPOSE
//  Parametrised multi-bit, multi-stage DFF pipeline with per-stage valid tracking.
//  Control inputs: clock enable, sync preset and sync clear, each with configurable polarity.
//  Serves as the generalised register-bank test design for QLF DFF inference and packing.
//  Exercises DFF+enable+set/reset mapping at width and depth.
// PARAMETERS
//  WIDTH    8      data bits per stage (>=1)
//  DEPTH    4      number of pipeline stages (>=1); also the latency in enabled cycles
//  INIT     0      WIDTH-bit data value loaded into every stage on rst
//  EN_POL   1      1: en active-high, 0: en active-low
//  PRE_POL  1      1: pre active-high, 0: pre active-low
//  CLR_POL  1      1: clr active-high, 0: clr active-low
// PORTS
//  clk        in   1                      clock, rising edge
//  rst        in   1                      synchronous reset, active-high
//  en         in   1                      shift enable (polarity EN_POL)
//  pre        in   1                      sync preset of all data to ones (polarity PRE_POL)
//  clr        in   1                      sync clear of data and valids (polarity CLR_POL)
//  d          in   WIDTH                  stage-0 data in
//  d_valid    in   1                      stage-0 valid in
//  err_inj    in   1                      invert stored parity at stage 0 (parity build only)
//  q          out  WIDTH                  last-stage data
//  q_valid    out  1                      last-stage valid
//  count      out  $clog2(DEPTH+1)        number of stages currently holding valid data
//  parity_err out  1                      q_valid & parity mismatch on q
// BEHAVIOUR
//  - All updates happen on the rising edge of clk. Priority per edge: rst > pre > clr > en > hold.
//  - rst: every stage data = INIT; all valids = 0; count = 0; stored parity = ^INIT.
//    Reset values of the outputs: q = INIT, q_valid = 0, count = 0, parity_err = 0.
//  - pre active, rst low:
//    - every stage data = {WIDTH{1'b1}}; valids and count hold.
//    - stored parity = ^{WIDTH{1'b1}}.
//    - pre wins over a simultaneous clr.
//  - clr active, rst/pre inactive:
//    - every stage data = 0; all valids = 0; count = 0; parity = 0.
//    - en is ignored on that edge.
//  - en active, no rst/pre/clr:
//    - stage0 <= d, v0 <= d_valid; stage i <= stage i-1 for i = 1..DEPTH-1.
//    - The last stage's contents are discarded.
//  - en inactive: all stages, valids and count hold (stall).
//  - Latency: d presented on an enabled edge appears on q after DEPTH enabled edges.
//    Stalled cycles add latency 1:1.
//  - q/q_valid are taken straight from the last-stage register. No combinational path from d to q.
//  - count is a register and always equals popcount(valid vector). On each enabled shift:
//    count += d_valid - v[DEPTH-1].
//    count never exceeds DEPTH and never wraps below 0.
//  - DEPTH=1: single register stage; count is 0 or 1.
//  - Changing an input mid-stall has no effect until the next enabled edge.
//    rst asserted mid-stream discards all in-flight data.
// CONFIGURATION
//  DFF_PIPE_PARITY_EN defined:
//    - Each stage carries one extra parity bit.
//    - On an enabled load, stage-0 parity = ^d ^ err_inj; the parity bit shifts with its data.
//    - parity_err = q_valid & (^q != stored parity), registered-output-derived with no
//      extra latency.
//  DFF_PIPE_PARITY_EN undefined:
//    - No parity storage; err_inj is ignored; parity_err is tied to 0.
//    - Ports are identical in both builds.
// TESTING
//  1 WIDTH=8 DEPTH=4, all polarities 1:
//    rst, then d=8'hA5/valid=1 with en=1 for 1 cycle, then valid=0.
//    -> q=8'hA5, q_valid=1 exactly 4 edges later; count goes 1,1,1,1,0.
//  2 Stall: stream 8'h01..8'h04 with en held low 2 cycles mid-stream.
//    -> order preserved; latency = 4 + 2 cycles; count constant during stall.
//  3 pre=1 and clr=1 on the same edge with 3 valid stages.
//    -> all data 8'hFF; count stays 3. Next edge clr=1 alone -> q=0, q_valid=0, count=0.
//  4 EN_POL=0 PRE_POL=0 CLR_POL=0:
//    - en=0 shifts; pre=0 presets; clr=0 clears.
//    - Same results as scenarios 1 and 3 with inverted control levels.
//  5 rst asserted with pipe full (count=4) and en=1.
//    -> next edge q=INIT, q_valid=0, count=0; d on that edge is dropped.
//  6 DFF_PIPE_PARITY_EN: d=8'h0F, err_inj=1, valid=1.
//    -> 4 edges later q_valid=1, parity_err=1. Repeat with err_inj=0 -> parity_err=0.
//    Without the macro -> parity_err=0 always.

Source files
------------

// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank: WIDTH x DEPTH register pipeline with per-stage valid bits,
// a valid-stage counter and enable/preset/clear controls of selectable polarity.
// Optional build macro DFF_PIPE_PARITY_EN adds a per-stage parity bit and
// drives parity_err; without it parity_err is tied low and err_inj is unused.
module dff_pipe_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter bit               EN_POL  = 1'b1,
  parameter bit               PRE_POL = 1'b1,
  parameter bit               CLR_POL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       pre,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic                       err_inj,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       parity_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic en_act_c;
  logic pre_act_c;
  logic clr_act_c;

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d;

  // Normalise control polarities to active-high.
  assign en_act_c  = (en  == EN_POL);
  assign pre_act_c = (pre == PRE_POL);
  assign clr_act_c = (clr == CLR_POL);

  // Next-state for data, valids and count: pre > clr > en > hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (pre_act_c) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '1;
      end
    end else if (clr_act_c) begin
      data_d  = '0;
      valid_d = '0;
      count_d = '0;
    end else if (en_act_c) begin
      data_d[0]  = d;
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Count tracks popcount of valids: one in at stage 0, one out of the last stage.
      count_d = count_q + CW'(d_valid) - CW'(valid_q[DEPTH-1]);
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= {DEPTH{INIT}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;

`ifdef DFF_PIPE_PARITY_EN
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic             ONES_PAR = ^ONES;
  localparam logic             INIT_PAR = ^INIT;

  logic [DEPTH-1:0] par_q, par_d;

  // Parity bit per stage follows the same priority as its data.
  always_comb begin
    par_d = par_q;
    if (pre_act_c) begin
      par_d = {DEPTH{ONES_PAR}};
    end else if (clr_act_c) begin
      par_d = '0;
    end else if (en_act_c) begin
      par_d[0] = (^d) ^ err_inj;
      for (int i = 1; i < DEPTH; i++) begin
        par_d[i] = par_q[i-1];
      end
    end
  end

  // Parity registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= {DEPTH{INIT_PAR}};
    end else begin
      par_q <= par_d;
    end
  end

  // Error flag derived from last-stage registers only; no added latency.
  assign parity_err = valid_q[DEPTH-1] & ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Bench for dff_pipe_bank: an active-high-control instance and an
// active-low-control instance see the same logical stimulus and must agree
// with the same expectations (directed table, then a scoreboarded stream).
module tb_dff_pipe_bank;

`ifdef DFF_PIPE_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, d_valid, err_inj;
  logic       en_p, pre_p, clr_p;
  logic       en_n, pre_n, clr_n;
  logic [7:0] d;
  logic [7:0] q_p, q_n;
  logic       qv_p, qv_n, pe_p, pe_n;
  logic [2:0] cnt_p, cnt_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_pipe_bank #(.WIDTH(8), .DEPTH(4), .INIT(8'h00),
                  .EN_POL(1'b1), .PRE_POL(1'b1), .CLR_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en_p), .pre(pre_p), .clr(clr_p),
    .d(d), .d_valid(d_valid), .err_inj(err_inj),
    .q(q_p), .q_valid(qv_p), .count(cnt_p), .parity_err(pe_p));

  dff_pipe_bank #(.WIDTH(8), .DEPTH(4), .INIT(8'h00),
                  .EN_POL(1'b0), .PRE_POL(1'b0), .CLR_POL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en_n), .pre(pre_n), .clr(clr_n),
    .d(d), .d_valid(d_valid), .err_inj(err_inj),
    .q(q_n), .q_valid(qv_n), .count(cnt_n), .parity_err(pe_n));

  typedef struct {
    logic       rst, en, pre, clr;
    logic [7:0] d;
    logic       dv, err;
    logic [7:0] eq;
    logic       eqv;
    logic [2:0] ecnt;
    logic       epe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       err;
  } item_t;

  vec_t  tbl[$];
  item_t sbq[$];
  logic [3:0] vm;
  logic [7:0] exp_q;
  logic       exp_pe;

  function automatic vec_t mk(input logic r, input logic e, input logic p, input logic c,
                              input logic [7:0] dd, input logic v, input logic er,
                              input logic [7:0] eq, input logic eqv, input logic [2:0] ec,
                              input logic epe);
    vec_t t;
    t.rst = r; t.en = e; t.pre = p; t.clr = c; t.d = dd; t.dv = v; t.err = er;
    t.eq = eq; t.eqv = eqv; t.ecnt = ec; t.epe = epe;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [7:0] eq, input logic eqv,
                          input logic [2:0] ec, input logic epe);
    chk({tag, " q"},      32'(q_p),   32'(eq));
    chk({tag, " qv"},     32'(qv_p),  32'(eqv));
    chk({tag, " cnt"},    32'(cnt_p), 32'(ec));
    chk({tag, " perr"},   32'(pe_p),  32'(epe));
    chk({tag, " n.q"},    32'(q_n),   32'(eq));
    chk({tag, " n.qv"},   32'(qv_n),  32'(eqv));
    chk({tag, " n.cnt"},  32'(cnt_n), 32'(ec));
    chk({tag, " n.perr"}, 32'(pe_n),  32'(epe));
  endtask

  task automatic apply(input logic r, input logic e, input logic p, input logic c,
                       input logic [7:0] dd, input logic v, input logic er);
    rst = r; d = dd; d_valid = v; err_inj = er;
    en_p = e;  pre_p = p;  clr_p = c;
    en_n = ~e; pre_n = ~p; clr_n = ~c;
  endtask

  // One scoreboarded cycle: drive, clock, update valid model, compare.
  task automatic sb_cycle(input logic e, input logic v, input logic [7:0] dd, input logic er,
                          input string tag);
    item_t it;
    apply(1'b0, e, 1'b0, 1'b0, dd, v, er);
    @(posedge clk);
    @(negedge clk);
    if (e) begin
      if (v) begin
        it.d = dd; it.err = er;
        sbq.push_back(it);
      end
      vm = {vm[2:0], v};
      if (vm[3]) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s sb_underflow actual=empty required=item", tag);
        end else begin
          it = sbq.pop_front();
          exp_q  = it.d;
          exp_pe = PE & it.err;
        end
      end
    end
    chk({tag, " qv"},    32'(qv_p),  32'(vm[3]));
    chk({tag, " cnt"},   32'(cnt_p), 32'($countones(vm)));
    chk({tag, " n.qv"},  32'(qv_n),  32'(vm[3]));
    chk({tag, " n.cnt"}, 32'(cnt_n), 32'($countones(vm)));
    if (vm[3]) begin
      chk({tag, " q"},      32'(q_p),  32'(exp_q));
      chk({tag, " perr"},   32'(pe_p), 32'(exp_pe));
      chk({tag, " n.q"},    32'(q_n),  32'(exp_q));
      chk({tag, " n.perr"}, 32'(pe_n), 32'(exp_pe));
    end else begin
      chk({tag, " perr0"},   32'(pe_p), 32'(0));
      chk({tag, " n.perr0"}, 32'(pe_n), 32'(0));
    end
  endtask

  initial begin
    // rst en pre clr d dv err | q qv cnt perr
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 8'h00,0,3'd0,0)); // reset state
    tbl.push_back(mk(0,1,0,0,8'hA5,1,0, 8'h00,0,3'd1,0)); // single item in
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'hA5,1,3'd1,0)); // 4th edge
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd0,0)); // shifted out
    tbl.push_back(mk(0,1,0,0,8'h11,1,0, 8'h00,0,3'd1,0)); // fill 3 stages
    tbl.push_back(mk(0,1,0,0,8'h22,1,0, 8'h00,0,3'd2,0));
    tbl.push_back(mk(0,1,0,0,8'h33,1,0, 8'h00,0,3'd3,0));
    tbl.push_back(mk(0,1,1,1,8'h44,1,0, 8'hFF,0,3'd3,0)); // pre beats clr and en
    tbl.push_back(mk(0,1,0,1,8'h44,1,0, 8'h00,0,3'd0,0)); // clr beats en
    tbl.push_back(mk(0,1,0,0,8'h55,1,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h55,1,3'd1,0));
    tbl.push_back(mk(0,0,1,0,8'h00,0,0, 8'hFF,1,3'd1,0)); // pre keeps valid, parity consistent
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'hFF,0,3'd0,0));
    tbl.push_back(mk(0,1,0,0,8'hA1,1,0, 8'hFF,0,3'd1,0)); // fill pipe
    tbl.push_back(mk(0,1,0,0,8'hA2,1,0, 8'hFF,0,3'd2,0));
    tbl.push_back(mk(0,1,0,0,8'hA3,1,0, 8'h00,0,3'd3,0));
    tbl.push_back(mk(0,1,0,0,8'hA4,1,0, 8'hA1,1,3'd4,0)); // full
    tbl.push_back(mk(1,1,0,0,8'hB5,1,0, 8'h00,0,3'd0,0)); // rst with full pipe
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd0,0)); // B5 dropped
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd0,0));
    tbl.push_back(mk(0,0,0,0,8'h77,1,1, 8'h00,0,3'd0,0)); // stalled input ignored
    tbl.push_back(mk(0,1,0,0,8'h0F,1,1, 8'h00,0,3'd1,0)); // injected parity error
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h0F,1,3'd1,PE));
    tbl.push_back(mk(0,1,0,0,8'h0F,1,0, 8'h00,0,3'd1,0)); // clean parity
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h00,0,3'd1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 8'h0F,1,3'd1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 8'h0F,1,3'd1,0)); // hold

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].pre, tbl[i].clr, tbl[i].d, tbl[i].dv, tbl[i].err);
      @(posedge clk);
      @(negedge clk);
      chk_both($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eqv, tbl[i].ecnt, tbl[i].epe);
    end

    // Reset before the scoreboarded stream.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    vm = '0; exp_q = '0; exp_pe = 1'b0;
    sbq.delete();

    // Ordered stream with a two-cycle stall and changing inputs during it.
    sb_cycle(1'b1, 1'b1, 8'h01, 1'b0, "stall0");
    sb_cycle(1'b1, 1'b1, 8'h02, 1'b0, "stall1");
    sb_cycle(1'b0, 1'b1, 8'hEE, 1'b1, "stall2");
    sb_cycle(1'b0, 1'b0, 8'hDD, 1'b0, "stall3");
    sb_cycle(1'b1, 1'b1, 8'h03, 1'b0, "stall4");
    sb_cycle(1'b1, 1'b1, 8'h04, 1'b0, "stall5");
    for (int i = 0; i < 4; i++) sb_cycle(1'b1, 1'b0, 8'h00, 1'b0, $sformatf("drain%0d", i));

    // Randomised stream with random stalls, valids and parity injections.
    for (int i = 0; i < 80; i++) begin
      sb_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 4; i++) sb_cycle(1'b1, 1'b0, 8'h00, 1'b0, $sformatf("flush%0d", i));
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
